// File: rtl/prog_autobaud.sv
// Autobaud detector for the programming UART: times a 0x55 sync byte on the
// RX line and drives the resulting clocks-per-bit divisor, or a default one.
module prog_autobaud #(
    parameter logic [15:0] DefaultClks = 16'd868,
    parameter int unsigned MinClks     = 4,
    parameter int unsigned IdleCycles  = 16,
    parameter int unsigned CntW        = 20
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        rx_i,
    input  logic        relock_i,
    output logic [15:0] clks_per_bit_o,
    output logic        valid_o,
    output logic        err_o
);
    localparam int unsigned XW = ((CntW > 17) ? CntW : 17) + 2;
    localparam int unsigned IW = $clog2(IdleCycles + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_MEAS,
        S_STOP,
        S_LOCK,
        S_ERR
    } state_t;

    state_t          state_reg;
    logic            sync1_reg;
    logic            sync2_reg;
    logic            rx_prev_reg;
    logic [IW-1:0]   idle_cnt_reg;
    logic [CntW-1:0] cnt_reg;
    logic [CntW-1:0] iv_reg;
    logic [CntW-1:0] meas_reg;
    logic [16:0]     w0_reg;
    logic [3:0]      edges_reg;

    logic          fall;
    logic          rise;
    logic          any_edge;
    logic          pol_ok;
    logic          in_range;
    logic          timeout;
    logic          stop_done;
    logic          res_bad;
    logic          go_err;
    logic [XW-1:0] interval;
    logic [XW-1:0] w0_x;
    logic [XW-1:0] lo_bound;
    logic [XW-1:0] hi_bound;
    logic [XW-1:0] half_x;
    logic [XW-1:0] res_x;
    logic [16:0]   w0_sat;

    always_comb begin
        fall     = rx_prev_reg & ~sync2_reg;
        rise     = ~rx_prev_reg & sync2_reg;
        any_edge = fall | rise;
        // edges_reg counts edges already accepted; odd-numbered edges must rise
        pol_ok   = edges_reg[0] ? fall : rise;
        interval = XW'(iv_reg) + XW'(1);
        w0_x     = XW'(w0_reg);
        lo_bound = w0_x - (w0_x >> 2);
        hi_bound = w0_x + (w0_x >> 2);
        in_range = (interval >= lo_bound) && (interval <= hi_bound);
        half_x   = w0_x >> 1;
        w0_sat   = (interval > XW'(17'h1FFFF)) ? 17'h1FFFF : interval[16:0];
        res_x    = (XW'(meas_reg) + XW'(4)) >> 3;
        res_bad  = (res_x > XW'(16'hFFFF)) || (res_x < XW'(MinClks));
        timeout  = (cnt_reg == {CntW{1'b1}});
        // in STOP, iv counts stop-bit cycles already seen high
        stop_done = (interval >= half_x);

        go_err = 1'b0;
        if (state_reg == S_MEAS) begin
            go_err = timeout ||
                     (any_edge && (!pol_ok || ((edges_reg != 4'd0) && !in_range)));
        end else if (state_reg == S_STOP) begin
            go_err = timeout || !sync2_reg || (stop_done && res_bad);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_reg      <= 1'b1;
            sync2_reg      <= 1'b1;
            rx_prev_reg    <= 1'b1;
            state_reg      <= S_IDLE;
            idle_cnt_reg   <= '0;
            cnt_reg        <= '0;
            iv_reg         <= '0;
            meas_reg       <= '0;
            w0_reg         <= '0;
            edges_reg      <= '0;
            clks_per_bit_o <= DefaultClks;
            valid_o        <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            sync1_reg   <= rx_i;
            sync2_reg   <= sync1_reg;
            rx_prev_reg <= sync2_reg;
            err_o       <= 1'b0;

            if (!enable_i) begin
                state_reg    <= S_IDLE;
                valid_o      <= 1'b0;
                idle_cnt_reg <= '0;
            end else if (go_err) begin
                state_reg      <= S_ERR;
                err_o          <= 1'b1;
                valid_o        <= 1'b0;
                clks_per_bit_o <= DefaultClks;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (!sync2_reg) begin
                            idle_cnt_reg <= '0;
                        end else if (idle_cnt_reg == IW'(IdleCycles - 1)) begin
                            idle_cnt_reg <= '0;
                            state_reg    <= S_ARMED;
                        end else begin
                            idle_cnt_reg <= idle_cnt_reg + 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (fall) begin
                            cnt_reg   <= '0;
                            iv_reg    <= '0;
                            edges_reg <= '0;
                            state_reg <= S_MEAS;
                        end
                    end
                    S_MEAS: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        iv_reg  <= iv_reg + 1'b1;
                        if (any_edge) begin
                            iv_reg    <= '0;
                            edges_reg <= edges_reg + 1'b1;
                            if (edges_reg == 4'd0) w0_reg <= w0_sat;
                            // falling edge at the start of b7 closes eight bit periods
                            if (edges_reg == 4'd7) meas_reg <= cnt_reg + 1'b1;
                            if (edges_reg == 4'd8) state_reg <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        cnt_reg <= cnt_reg + 1'b1;
                        iv_reg  <= iv_reg + 1'b1;
                        if (stop_done) begin
                            state_reg      <= S_LOCK;
                            clks_per_bit_o <= res_x[15:0];
                            valid_o        <= 1'b1;
                        end
                    end
                    S_LOCK: begin
                        if (relock_i) begin
                            state_reg    <= S_IDLE;
                            valid_o      <= 1'b0;
                            idle_cnt_reg <= '0;
                        end
                    end
                    S_ERR: begin
                        state_reg    <= S_IDLE;
                        idle_cnt_reg <= '0;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end
endmodule
